div_iter: RTL and testbench
===========================

# div_iter

Parametrised multi-cycle integer divider for the execute stage. It serves DIV/DIVU and writes its results to HI/LO: quotient to LO, remainder to HI. It takes one radix-2 restoring iteration per cycle with fixed latency. Signed and unsigned modes are selected per operation. A cancel input lets the pipeline kill an in-flight divide on exception or flush. A start/busy/done handshake lets the pipeline stall EX while busy.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4).
- clk  in  1  rising-edge clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a divide; sampled only when the block is in IDLE or DONE.
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled together with start.
- cancel  in  1  abort the current operation; takes priority over start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  registered quotient, destined for LO.
- remainder  out  WIDTH  registered remainder, destined for HI.
- div_zero  out  1  registered flag: the last completed operation had divisor == 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1 and cancel=0 → CALC:
  - latch the operand magnitudes (two's-complement absolute value when sign=1);
  - latch the sign of the quotient (dividend sign XOR divisor sign) and the remainder sign (dividend sign), both only when sign=1;
  - clear the iteration counter.
- IDLE/DONE with start=0 → IDLE.
- CALC, each cycle:
  - shift the partial remainder left by one, bringing in the next dividend MSB;
  - trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor;
  - if the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0;
  - increment the counter.
- CALC → DONE on the edge that completes iteration WIDTH. Results are registered on that edge:
  - quotient is negated if its latched sign is set;
  - remainder is negated if the dividend was negative.
- Signed semantics follow MIPS: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case: signed (−2^(WIDTH−1)) / (−1) gives quotient = 2^(WIDTH−1) bit pattern (wraps), remainder = 0. No flag is raised.
- Divide by zero, in either mode:
  - quotient = all ones, remainder = dividend as supplied, div_zero = 1;
  - full latency is still taken.
- cancel=1 in CALC → IDLE on the next edge. No done is produced; quotient, remainder and div_zero keep their previous values.
- start while in CALC is ignored; operands are not re-sampled.
- quotient, remainder and div_zero hold until the next completed operation.

## Timing
- Reset values: every output is 0 (busy=0, done=0, quotient=0, remainder=0, div_zero=0); state is IDLE and the counter is 0.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously). The operation is lost.
- Cycle numbering: start is high in cycle 0.
  - busy=1 in cycles 1..WIDTH.
  - done=1 and results valid in cycle WIDTH+1, when busy=0.
  - Latency is WIDTH+1 cycles from start to done.
- Back-to-back: start may be asserted in the done cycle (WIDTH+1). busy rises in cycle WIDTH+2, giving a throughput of one divide per WIDTH+1 cycles.
- done is high for exactly one cycle and never while busy=1.
- Simultaneous cancel and start:
  - in IDLE/DONE: start is ignored, and the state stays or goes to IDLE;
  - in CALC: cancel applies.
- The pipeline must stall EX while busy is high. busy is a registered output with no combinational path from inputs.

## Test plan
- WIDTH=32, unsigned: 100 / 7, start in cycle 0 → done in cycle 33, quotient=14, remainder=2, div_zero=0. busy=1 in cycles 1..32 only.
- WIDTH=32, signed: 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- WIDTH=32, signed: 7 / 0xFFFFFFFE (−2) → quotient=0xFFFFFFFD (−3), remainder=1.
- WIDTH=32, signed: 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- WIDTH=32, unsigned: 5 / 0 → done in cycle 33, quotient=0xFFFFFFFF, remainder=5, div_zero=1.
- Cancel case:
  - Setup: a completed divide (100/7) first, then 1000/3 started; cancel pulsed in cycle 10.
  - Required during cancel: busy=0 from cycle 11, no done pulse; outputs still show 14 and 2.
  - Required after cancel: a fresh start of 9/4 in cycle 12 gives done in cycle 45, quotient=2, remainder=1.
- WIDTH=8 instance, unsigned 200/3 → done in cycle 9, quotient=66, remainder=2. Back-to-back start of 255/16 in cycle 9 → done in cycle 18, quotient=15, remainder=15.
- resetn pulsed low in cycle 5 of a divide → all outputs 0 immediately, and no done follows.

Source files
------------

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// One iteration per cycle, fixed latency of WIDTH+1 cycles from start to done.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvdRaw;
  logic             r_negQ;
  logic             r_negR;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quoOut;
  logic [WIDTH-1:0] r_remOut;
  logic             r_zero;

  logic             w_dvdNeg;
  logic             w_dvsNeg;
  logic [WIDTH-1:0] w_dvdMag;
  logic [WIDTH-1:0] w_dvsMag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_dvsZero;
  logic [WIDTH-1:0] w_quoFinal;
  logic [WIDTH-1:0] w_remFinal;

  assign w_dvdNeg = i_sign & i_dividend[WIDTH-1];
  assign w_dvsNeg = i_sign & i_divisor[WIDTH-1];
  assign w_dvdMag = w_dvdNeg ? -i_dividend : i_dividend;
  assign w_dvsMag = w_dvsNeg ? -i_divisor : i_divisor;

  // r_quo starts out holding the dividend magnitude; its MSB feeds the partial remainder
  // while quotient bits fill in from the bottom.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_fits    = (w_shift >= {1'b0, r_dvs});
  assign w_remNext = w_fits ? WIDTH'(w_diff) : WIDTH'(w_shift);
  assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};

  assign w_dvsZero  = (r_dvs == '0);
  assign w_quoFinal = w_dvsZero ? '1 : (r_negQ ? -w_quoNext : w_quoNext);
  assign w_remFinal = w_dvsZero ? r_dvdRaw : (r_negR ? -w_remNext : w_remNext);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_dvdRaw <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quoOut <= '0;
      r_remOut <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start && !i_cancel) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_dvdMag;
            r_dvs    <= w_dvsMag;
            r_dvdRaw <= i_dividend;
            r_negQ   <= w_dvdNeg ^ w_dvsNeg;
            r_negR   <= w_dvdNeg;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (i_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_quoOut <= w_quoFinal;
              r_remOut <= w_remFinal;
              r_zero   <= w_dvsZero;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quoOut;
  assign o_remainder = r_remOut;
  assign o_div_zero  = r_zero;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: a 32-bit and an 8-bit instance checked every cycle against an
// arithmetic model of in-flight operations, plus hand-computed literal results.
module tb_div_iter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 0, sign32 = 0, cancel32 = 0;
  logic [31:0] dvd32 = '0, dvs32 = '0;
  logic        busy32, done32, zero32;
  logic [31:0] q32, r32;

  logic        start8 = 0, sign8 = 0, cancel8 = 0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        busy8, done8, zero8;
  logic [7:0]  q8, r8;

  div_iter #(.WIDTH(32)) u32 (
    .i_clk(clk), .i_resetn(resetn), .i_start(start32), .i_sign(sign32),
    .i_cancel(cancel32), .i_dividend(dvd32), .i_divisor(dvs32),
    .o_busy(busy32), .o_done(done32), .o_quotient(q32),
    .o_remainder(r32), .o_div_zero(zero32)
  );

  div_iter #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_resetn(resetn), .i_start(start8), .i_sign(sign8),
    .i_cancel(cancel8), .i_dividend(dvd8), .i_divisor(dvs8),
    .o_busy(busy8), .o_done(done8), .o_quotient(q8),
    .o_remainder(r8), .o_div_zero(zero8)
  );

  typedef struct {
    int          id;
    int          st;
    int          kill;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } op_t;

  op_t         ops[$];
  logic [31:0] hq[2];
  logic [31:0] hr[2];
  logic        hz[2];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        checkEn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Result of a divide computed with plain signed/unsigned arithmetic at width w.
  function automatic void model(input int w, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint mask, as, bs;
    mask = (longint'(1) << w) - 1;
    as = longint'(a) & mask;
    bs = longint'(b) & mask;
    if (sgn) begin
      if (as >= (longint'(1) << (w - 1))) as = as - (longint'(1) << w);
      if (bs >= (longint'(1) << (w - 1))) bs = bs - (longint'(1) << w);
    end
    if (bs == 0) begin
      q = 32'(mask);
      r = 32'(longint'(a) & mask);
      z = 1'b1;
    end else begin
      q = 32'((as / bs) & mask);
      r = 32'((as % bs) & mask);
      z = 1'b0;
    end
  endfunction

  // Per-cycle comparison: busy/done derived from each operation's start cycle and kill cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int id = 0; id < 2; id++) begin
        int   w;
        int   last;
        logic eb, ed;
        w  = (id == 0) ? 32 : 8;
        eb = 1'b0;
        ed = 1'b0;
        foreach (ops[k]) begin
          if (ops[k].id == id) begin
            last = ops[k].st + w;
            if (ops[k].kill >= 0 && ops[k].kill < last) last = ops[k].kill;
            if (cyc > ops[k].st && cyc <= last) eb = 1'b1;
            if (ops[k].kill < 0 && cyc == ops[k].st + w + 1) begin
              ed = 1'b1;
              hq[id] = ops[k].q;
              hr[id] = ops[k].r;
              hz[id] = ops[k].z;
            end
          end
        end
        for (int k = ops.size() - 1; k >= 0; k--)
          if (ops[k].id == id && cyc > ops[k].st + w + 1) ops.delete(k);
        if (id == 0) begin
          checkOutput("busy32", {31'b0, busy32}, {31'b0, eb});
          checkOutput("done32", {31'b0, done32}, {31'b0, ed});
          checkOutput("quot32", q32, hq[0]);
          checkOutput("rem32", r32, hr[0]);
          checkOutput("zero32", {31'b0, zero32}, {31'b0, hz[0]});
        end else begin
          checkOutput("busy8", {31'b0, busy8}, {31'b0, eb});
          checkOutput("done8", {31'b0, done8}, {31'b0, ed});
          checkOutput("quot8", {24'b0, q8}, hq[1]);
          checkOutput("rem8", {24'b0, r8}, hr[1]);
          checkOutput("zero8", {31'b0, zero8}, {31'b0, hz[1]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b);
    op_t o;
    o.id   = id;
    o.st   = cyc;
    o.kill = -1;
    model((id == 0) ? 32 : 8, sgn, a, b, o.q, o.r, o.z);
    ops.push_back(o);
    if (id == 0) begin
      start32 = 1'b1; sign32 = sgn; dvd32 = a; dvs32 = b;
    end else begin
      start8 = 1'b1; sign8 = sgn; dvd8 = a[7:0]; dvs8 = b[7:0];
    end
  endtask

  task automatic clearStarts();
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  task automatic checkLit32(input string nm, input logic [31:0] q, input logic [31:0] r,
                            input logic z);
    checkOutput({nm, " done"}, {31'b0, done32}, 32'd1);
    checkOutput({nm, " quot"}, q32, q);
    checkOutput({nm, " rem"}, r32, r);
    checkOutput({nm, " zero"}, {31'b0, zero32}, {31'b0, z});
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
    logic        z;
    string       nm;
  } vec_t;

  vec_t vecs[4];
  int   t;

  initial begin
    hq = '{default: '0};
    hr = '{default: '0};
    hz = '{default: 1'b0};
    vecs[0] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s -7/2"};
    vecs[1] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, "s 7/-2"};
    vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, "s ovf"};
    vecs[3] = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, "u 5/0"};

    repeat (3) step();
    checkOutput("reset busy32", {31'b0, busy32}, 32'd0);
    checkOutput("reset done32", {31'b0, done32}, 32'd0);
    checkOutput("reset quot32", q32, 32'd0);
    checkOutput("reset rem32", r32, 32'd0);
    checkOutput("reset zero32", {31'b0, zero32}, 32'd0);
    checkOutput("reset busy8", {31'b0, busy8}, 32'd0);
    resetn = 1'b1;
    step();
    checkEn = 1'b1;

    // 100/7 on the wide unit alongside 200/3 then back-to-back 255/16 on the narrow one.
    applyStimulus(0, 1'b0, 32'd100, 32'd7);
    applyStimulus(1, 1'b0, 32'd200, 32'd3);
    step(); clearStarts();
    checkOutput("u100/7 busy c1", {31'b0, busy32}, 32'd1);
    repeat (8) step();
    checkOutput("w8 200/3 done", {31'b0, done8}, 32'd1);
    checkOutput("w8 200/3 quot", {24'b0, q8}, 32'd66);
    checkOutput("w8 200/3 rem", {24'b0, r8}, 32'd2);
    applyStimulus(1, 1'b0, 32'd255, 32'd16);
    step(); clearStarts();
    repeat (8) step();
    checkOutput("w8 255/16 done", {31'b0, done8}, 32'd1);
    checkOutput("w8 255/16 quot", {24'b0, q8}, 32'd15);
    checkOutput("w8 255/16 rem", {24'b0, r8}, 32'd15);
    repeat (14) step();
    checkOutput("u100/7 busy c32", {31'b0, busy32}, 32'd1);
    step();
    checkLit32("u100/7", 32'd14, 32'd2, 1'b0);
    checkOutput("u100/7 busy c33", {31'b0, busy32}, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].sgn, vecs[i].a, vecs[i].b);
      step(); clearStarts();
      repeat (32) step();
      checkLit32(vecs[i].nm, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Cancel: 100/7 completes, 1000/3 is killed in its cycle 10, then 9/4 starts in cycle 12.
    applyStimulus(0, 1'b0, 32'd100, 32'd7);
    step(); clearStarts();
    repeat (32) step();
    checkLit32("pre-cancel", 32'd14, 32'd2, 1'b0);
    step();
    t = cyc;
    applyStimulus(0, 1'b0, 32'd1000, 32'd3);
    step(); clearStarts();
    repeat (9) step();
    foreach (ops[k]) if (ops[k].id == 0 && ops[k].st == t) ops[k].kill = cyc;
    cancel32 = 1'b1;
    step();
    cancel32 = 1'b0;
    checkOutput("cancel busy", {31'b0, busy32}, 32'd0);
    checkOutput("cancel quot", q32, 32'd14);
    checkOutput("cancel rem", r32, 32'd2);
    step();
    applyStimulus(0, 1'b0, 32'd9, 32'd4);
    step(); clearStarts();
    repeat (7) step();
    start32 = 1'b1; dvd32 = 32'd77; dvs32 = 32'd5;
    step(); clearStarts();
    repeat (24) step();
    checkOutput("post-cancel cycle", cyc, t + 45);
    checkLit32("u9/4", 32'd2, 32'd1, 1'b0);

    // start together with cancel while idle must not launch anything.
    step();
    start32 = 1'b1; cancel32 = 1'b1; dvd32 = 32'd50; dvs32 = 32'd5;
    step();
    start32 = 1'b0; cancel32 = 1'b0;
    repeat (3) step();
    checkOutput("start+cancel busy", {31'b0, busy32}, 32'd0);

    // Asynchronous reset in cycle 5 of a signed divide.
    applyStimulus(0, 1'b1, 32'hFFFFFFE2, 32'd4);
    step(); clearStarts();
    repeat (4) step();
    foreach (ops[k]) ops[k].kill = cyc - 1;
    hq = '{default: '0};
    hr = '{default: '0};
    hz = '{default: 1'b0};
    resetn = 1'b0;
    #1;
    checkOutput("rst busy", {31'b0, busy32}, 32'd0);
    checkOutput("rst quot", q32, 32'd0);
    checkOutput("rst rem", r32, 32'd0);
    checkOutput("rst done", {31'b0, done32}, 32'd0);
    step();
    resetn = 1'b1;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
